// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: data-bus responder answering CPU load/store requests from a word SRAM
// Stands in for the DCache on the MEM-stage request/response bus, with LATENCY wait cycles per access.
// Ports: clk, rst (async, active-high); valid/op/addr/wdata/wstrb request; ready gates acceptance;
//        busy high while a request waits; rdata holds the last load result.
// Optional: define DBUS_RESP_RANDOM_STALL_EN to add 0..3 LFSR-chosen extra wait cycles per request.
module dbus_sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        ready,
  output logic        busy,
  output logic [31:0] rdata
);
  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_check
    $error("dbus_sram_responder: LATENCY must be in 0..15");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
`ifdef DBUS_RESP_RANDOM_STALL_EN
  // Extra stall can push the wait to LATENCY+3, so the counter gets one more bit.
  localparam int CW = 5;
  logic [15:0] lfsr;
  logic [CW-1:0] wait_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign wait_len = CW'(LATENCY) + CW'(lfsr[1:0]);
`else
  localparam int CW = 4;
  logic [CW-1:0] wait_len;
  assign wait_len = CW'(LATENCY);
`endif
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [CW-1:0] cnt, cnt_d;
  logic req_op;
  logic [DEPTH_LOG2-1:0] req_idx, idx, acc_idx;
  logic [31:0] req_wdata, acc_wdata;
  logic [3:0] req_wstrb, acc_wstrb;
  logic accept, do_access, acc_op;
  logic unused_addr;
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign busy = state == WAIT;
  assign accept = valid && ready && !busy;
  assign idx = addr[DEPTH_LOG2+1:2];
  // Zero-wait accesses use the live request; delayed ones use the copy latched at acceptance.
  assign acc_op = busy ? req_op : op;
  assign acc_idx = busy ? req_idx : idx;
  assign acc_wdata = busy ? req_wdata : wdata;
  assign acc_wstrb = busy ? req_wstrb : wstrb;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    do_access = 1'b0;
    if (state == WAIT) begin
      cnt_d = cnt - CW'(1);
      do_access = cnt == CW'(1);
      state_d = do_access ? RESP : WAIT;
    end else if (accept) begin
      do_access = wait_len == '0;
      state_d = do_access ? RESP : WAIT;
      cnt_d = wait_len;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      req_op <= 1'b0;
      req_idx <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      rdata <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        req_op <= op;
        req_idx <= idx;
        req_wdata <= wdata;
        req_wstrb <= wstrb;
      end
      if (do_access && !acc_op) rdata <= mem[acc_idx];
    end
  end
  // SRAM has no reset; a store cancelled by reset never reaches it.
  always_ff @(posedge clk)
    if (do_access && acc_op && !rst)
      for (int b = 0; b < 4; b++)
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: scoreboard bench driving a LATENCY=0 and a LATENCY=3 responder
module tb_dbus_sram_responder;
  typedef struct packed {int due; logic [31:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid[2], op[2], ready[2], busy[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic [3:0] wstrb[2];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q[2][$];
  logic [31:0] exp_rd[2];
  logic [31:0] mm[2][1024];
  int bs[2], be[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .valid(valid[0]), .op(op[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .ready(ready[0]), .busy(busy[0]), .rdata(rdata[0]));
  dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .valid(valid[1]), .op(op[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .ready(ready[1]), .busy(busy[1]), .rdata(rdata[1]));
  function automatic int lat(input int d);
    return d == 0 ? 0 : 3;
  endfunction
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, want);
    end
  endtask
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0 && q[d][0].due == cyc) begin
        exp_t e;
        e = q[d].pop_front();
        exp_rd[d] = e.v;
        chk("load", d, rdata[d], e.v);
      end
      chk("hold", d, rdata[d], exp_rd[d]);
      chk("busy", d, {31'b0, busy[d]}, {31'b0, cyc >= bs[d] && cyc <= be[d]});
    end
  end
  task automatic req(input int d, input logic o, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] s, input int nr);
    int c, k;
    for (int i = 0; i <= nr; i++) begin
      @(negedge clk);
      valid[d] = 1'b1; op[d] = o; addr[d] = a; wdata[d] = w; wstrb[d] = s; ready[d] = i == nr;
    end
    c = cyc;
    k = (a / 4) % 1024;
    if (o) begin
      for (int b = 0; b < 4; b++) if (s[b]) mm[d][k][8*b +: 8] = w[8*b +: 8];
    end else q[d].push_back('{c + lat(d) + 1, mm[d][k]});
    if (lat(d) > 0) begin
      bs[d] = c + 1;
      be[d] = c + lat(d);
    end
    repeat (lat(d)) begin
      @(negedge clk);
      valid[d] = 1'($urandom); op[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
      wstrb[d] = 4'($urandom); ready[d] = 1'($urandom);
    end
  endtask
  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      valid[d] = 1'b0; ready[d] = 1'($urandom);
    end
  endtask
  task automatic rnd(input int d);
    for (int i = 0; i < 16; i++) req(d, 1'b1, 32'h4000 + 32'(i * 4), $urandom, 4'hF, 0);
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | (32'(32'($urandom_range(0, 15)) * 32'h4)) | ($urandom & 32'h3);
      a[11:6] = 6'h0;
      a[14] = 1'b1;
      req(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3) == 0 ? 2 : 0);
      if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
    end
    idle(d, 6);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; op[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; ready[d] = 1'b0;
      exp_rd[d] = '0; bs[d] = 1; be[d] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_busy", 0, {31'b0, busy[0]}, 32'h0);
    chk("reset_rdata", 1, rdata[1], 32'h0);
    #2 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req(d, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0);
      req(d, 1'b0, 32'h100, 32'h0, 4'h0, 0);
      req(d, 1'b1, 32'h100, 32'h0000AB00, 4'b0010, 0);
      req(d, 1'b0, 32'h100, 32'h0, 4'h0, 0);
      req(d, 1'b1, 32'h104, 32'h11111111, 4'h0, 0);
      req(d, 1'b1, 32'h200, 32'h5A5A0200, 4'hF, 0);
      req(d, 1'b0, 32'h100, 32'h0, 4'h0, 0);
      req(d, 1'b0, 32'h200, 32'h0, 4'h0, 5);
      req(d, 1'b0, 32'h100, 32'h0, 4'h0, 0);
      idle(d, 3);
    end
    @(negedge clk);
    valid[1] = 1'b1; op[1] = 1'b1; addr[1] = 32'h100; wdata[1] = 32'h12345678; wstrb[1] = 4'hF;
    ready[1] = 1'b1;
    bs[1] = cyc + 1;
    be[1] = cyc + 3;
    @(negedge clk);
    valid[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 1, {31'b0, busy[1]}, 32'h0);
    chk("rst_rdata", 1, rdata[1], 32'h0);
    chk("rst_rdata", 0, rdata[0], 32'h0);
    be[1] = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    req(1, 1'b0, 32'h100, 32'h0, 4'h0, 0);
    for (int d = 0; d < 2; d++) begin
      req(d, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
      req(d, 1'b0, 32'h0, 32'h0, 4'h0, 0);
      idle(d, 4);
    end
    chk("alias_model", 1, mm[1][0], 32'hCAFEF00D);
    fork
      rnd(0);
      rnd(1);
    join
    for (int d = 0; d < 2; d++) chk("drain", d, 32'(q[d].size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
